// File: rtl/shared_counter_sched_pkg.sv
// ----------------------------------------------------------------------------
// shared_counter_sched_pkg
// Shared definitions for the shared-counter scheduler slice: the FSM state
// encoding, the default counter width and the requester id constants.
// No ports (package).
// ----------------------------------------------------------------------------
package shared_counter_sched_pkg;

    // Default width of the shared counter and of the target lengths
    localparam int CW_DEFAULT = 4;

    // Scheduler states, 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLR   = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Requester ids, as stored in the "last served" register
    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/shared_counter_sched_if.sv
// ----------------------------------------------------------------------------
// shared_counter_sched_if
// Bundle of the requester-side and counter-side signals of the scheduler.
//   req[1:0]   per-requester request level
//   step[1:0]  per-requester count strobe
//   len0/len1  per-requester target length
//   ctr_q      current value of the shared counter
//   ctr_reset  synchronous clear to the counter
//   ctr_en     count enable to the counter
//   gnt[1:0]   one-hot grant
//   done[1:0]  one-cycle completion pulse
//   busy       scheduler not idle
// Modports: master = requesters plus counter (environment side),
//           slave  = the scheduler itself.
// ----------------------------------------------------------------------------
interface shared_counter_sched_if
    import shared_counter_sched_pkg::*;
#(
    parameter int CW = CW_DEFAULT
);

    logic [1:0]    req;
    logic [1:0]    step;
    logic [CW-1:0] len0;
    logic [CW-1:0] len1;
    logic [CW-1:0] ctr_q;
    logic          ctr_reset;
    logic          ctr_en;
    logic [1:0]    gnt;
    logic [1:0]    done;
    logic          busy;

    modport master (
        output req, step, len0, len1, ctr_q,
        input  ctr_reset, ctr_en, gnt, done, busy
    );

    modport slave (
        input  req, step, len0, len1, ctr_q,
        output ctr_reset, ctr_en, gnt, done, busy
    );

endinterface

// File: rtl/shared_counter_sched_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin picker.
//   req_i[1:0]  request levels
//   last_i      id of the requester served last
//   pick_o[1:0] one-hot pick, all zero when nobody requests
// ----------------------------------------------------------------------------
module rr_arb2
    import shared_counter_sched_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] pick_o
);

    // A lone requester always wins; on a tie the one not served last wins
    always_comb begin
        pick_o = 2'b00;
        case (req_i)
            2'b01:   pick_o = 2'b01;
            2'b10:   pick_o = 2'b10;
            2'b11:   pick_o = (last_i == REQ_ID1) ? 2'b01 : 2'b10;
            default: pick_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/shared_counter_sched.sv
// ----------------------------------------------------------------------------
// shared_counter_sched
// Shares one external enabled up-counter between two requesters. A requester
// is granted round-robin, the counter is cleared, then advanced on the
// owner's step strobes until it equals the owner's target length, at which
// point a one-cycle done pulse is returned to the owner.
//   clock  system clock
//   reset  synchronous active-high reset
//   bus    scheduler side (slave modport) of shared_counter_sched_if
// ----------------------------------------------------------------------------
module shared_counter_sched
    import shared_counter_sched_pkg::*;
#(
    parameter int CW = CW_DEFAULT
)(
    input  logic                         clock,
    input  logic                         reset,
    shared_counter_sched_if.slave        bus
);

    state_e        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    done_q, done_d;
    logic [CW-1:0] len_q, len_d;
    logic          last_q, last_d;

    logic [1:0]    pick;
    logic          ownerReq;
    logic          ownerStep;
    logic          countEn;

    rr_arb2 u_arb (
        .req_i  (bus.req),
        .last_i (last_q),
        .pick_o (pick)
    );

    // Only the granted requester's request and step are honoured
    assign ownerReq  = |(bus.req  & gnt_q);
    assign ownerStep = |(bus.step & gnt_q);

    // Next-state decode; an owner dropping its request aborts the job
    // without a done pulse and without touching the counter
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = 2'b00;
        len_d   = len_q;
        last_d  = last_q;
        countEn = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick != 2'b00) begin
                    gnt_d   = pick;
                    len_d   = pick[1] ? bus.len1 : bus.len0;
                    state_d = ST_CLR;
                end
            end
            ST_CLR: begin
                if (!ownerReq) begin
                    gnt_d   = 2'b00;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (!ownerReq) begin
                    gnt_d   = 2'b00;
                    state_d = ST_IDLE;
                end else if (bus.ctr_q == len_q) begin
                    done_d  = gnt_q;
                    state_d = ST_DONE;
                end else begin
                    countEn = ownerStep;
                end
            end
            ST_DONE: begin
                last_d  = gnt_q[1] ? REQ_ID1 : REQ_ID0;
                gnt_d   = 2'b00;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; last resets to requester 1 so requester 0 wins the
    // first tie
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            len_q   <= '0;
            last_q  <= REQ_ID1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            len_q   <= len_d;
            last_q  <= last_d;
        end
    end

    // Counter control is combinational so the counter moves on the very
    // next edge; reset forces a clear so the counter is never left stale
    assign bus.ctr_reset = reset || (state_q == ST_CLR);
    assign bus.ctr_en    = countEn && !reset;
    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shared_counter_sched.sv
// ----------------------------------------------------------------------------
// tb_shared_counter_sched
// Directed bench for shared_counter_sched paired with a 4-bit enabled
// counter with synchronous clear. Inputs change 1 time unit after the rising
// edge and outputs are sampled at that same point.
// ----------------------------------------------------------------------------
module tb_shared_counter_sched;

    localparam int CW = 4;

    // Step pattern for requester 1 in the stall test, element i in bit i,
    // with the counter value expected after each of those cycles
    localparam logic [5:0] STALL_PAT = 6'b111001;
    localparam int STALL_EXP [6] = '{1, 1, 1, 2, 3, 4};

    logic          clock;
    logic          reset;
    logic [CW-1:0] ctrCount;
    int            checkCount;
    int            passCount;
    int            cycles;
    logic          hit;

    shared_counter_sched_if #(.CW(CW)) bus ();

    shared_counter_sched #(.CW(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per period
    always #5 clock = ~clock;

    // The shared counter: synchronous clear wins over enable
    always_ff @(posedge clock) begin
        if (bus.ctr_reset)
            ctrCount <= '0;
        else if (bus.ctr_en)
            ctrCount <= ctrCount + 1'b1;
    end

    assign bus.ctr_q = ctrCount;

    // Advance one edge and settle
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive all requester inputs at once
    task automatic applyStimulus(input logic [1:0] reqV, input logic [1:0] stepV,
                                 input logic [CW-1:0] len0V, input logic [CW-1:0] len1V);
        bus.req  = reqV;
        bus.step = stepV;
        bus.len0 = len0V;
        bus.len1 = len1V;
    endtask

    // Count one comparison and report it if it does not hold
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected)
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        else
            passCount++;
    endtask

    // Two reset edges with all requests low, checking the reset outputs
    task automatic doReset();
        applyStimulus(2'b00, 2'b00, '0, '0);
        reset = 1'b1;
        tick();
        tick();
        checkOutput("rst_ctr_reset", {31'd0, bus.ctr_reset}, 32'd1);
        checkOutput("rst_ctr_en",    {31'd0, bus.ctr_en},    32'd0);
        checkOutput("rst_gnt",       {30'd0, bus.gnt},       32'd0);
        checkOutput("rst_done",      {30'd0, bus.done},      32'd0);
        checkOutput("rst_busy",      {31'd0, bus.busy},      32'd0);
        checkOutput("rst_ctr_q",     {28'd0, bus.ctr_q},     32'd0);
        reset = 1'b0;
    endtask

    // Wait until the counter shows a given value, at most maxCycles edges
    task automatic waitCount(input logic [CW-1:0] target, input int maxCycles,
                             output logic found);
        found = 1'b0;
        for (int i = 0; i < maxCycles && !found; i++) begin
            tick();
            if (bus.ctr_q == target)
                found = 1'b1;
        end
    endtask

    initial begin
        clock      = 1'b0;
        reset      = 1'b1;
        checkCount = 0;
        passCount  = 0;
        applyStimulus(2'b00, 2'b00, '0, '0);

        // ---- Single job, requester 0, length 3 ----
        doReset();
        applyStimulus(2'b01, 2'b01, 4'd3, 4'd0);
        tick();
        checkOutput("single_gnt",       {30'd0, bus.gnt},       32'h1);
        checkOutput("single_clr_reset", {31'd0, bus.ctr_reset}, 32'd1);
        checkOutput("single_clr_busy",  {31'd0, bus.busy},      32'd1);
        tick();
        checkOutput("single_ctr0",      {28'd0, bus.ctr_q},     32'd0);
        checkOutput("single_cnt_en",    {31'd0, bus.ctr_en},    32'd1);
        checkOutput("single_cnt_reset", {31'd0, bus.ctr_reset}, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkOutput("single_ctr",     {28'd0, bus.ctr_q}, i);
            checkOutput("single_no_done", {30'd0, bus.done},  32'd0);
        end
        checkOutput("single_en_at_len", {31'd0, bus.ctr_en}, 32'd0);
        tick();
        checkOutput("single_done",      {30'd0, bus.done},  32'h1);
        checkOutput("single_done_gnt",  {30'd0, bus.gnt},   32'h1);
        checkOutput("single_done_ctr",  {28'd0, bus.ctr_q}, 32'd3);
        applyStimulus(2'b00, 2'b00, 4'd3, 4'd0);
        tick();
        checkOutput("single_end_done",  {30'd0, bus.done},  32'd0);
        checkOutput("single_end_gnt",   {30'd0, bus.gnt},   32'd0);
        checkOutput("single_end_busy",  {31'd0, bus.busy},  32'd0);

        // ---- Round robin, both requesting, len0=2 len1=1 ----
        doReset();
        applyStimulus(2'b11, 2'b11, 4'd2, 4'd1);
        for (int j = 0; j < 4; j++) begin
            logic [1:0] expGnt;
            int         expLen;
            expGnt = (j % 2 == 0) ? 2'b01 : 2'b10;
            expLen = (j % 2 == 0) ? 2 : 1;
            tick();
            checkOutput("rr_gnt", {30'd0, bus.gnt}, {30'd0, expGnt});
            for (int k = 0; k <= expLen; k++) begin
                tick();
                checkOutput("rr_no_early_done", {30'd0, bus.done}, 32'd0);
            end
            tick();
            checkOutput("rr_done",     {30'd0, bus.done},  {30'd0, expGnt});
            checkOutput("rr_done_ctr", {28'd0, bus.ctr_q}, expLen);
            if (j == 3)
                applyStimulus(2'b00, 2'b00, 4'd2, 4'd1);
            tick();
            checkOutput("rr_idle_gnt",  {30'd0, bus.gnt},  32'd0);
            checkOutput("rr_idle_busy", {31'd0, bus.busy}, 32'd0);
        end

        // ---- Step gating, requester 1, length 4 ----
        doReset();
        applyStimulus(2'b10, 2'b01, 4'd0, 4'd4);
        tick();
        checkOutput("stall_gnt", {30'd0, bus.gnt}, 32'h2);
        tick();
        checkOutput("stall_ctr0", {28'd0, bus.ctr_q}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2'b10, {STALL_PAT[i], 1'b1}, 4'd0, 4'd4);
            tick();
            checkOutput("stall_ctr", {28'd0, bus.ctr_q}, STALL_EXP[i]);
        end
        applyStimulus(2'b10, 2'b11, 4'd0, 4'd4);
        tick();
        checkOutput("stall_done",     {30'd0, bus.done},  32'h2);
        checkOutput("stall_no_over",  {28'd0, bus.ctr_q}, 32'd4);
        applyStimulus(2'b00, 2'b00, 4'd0, 4'd4);
        tick();
        checkOutput("stall_end_gnt",  {30'd0, bus.gnt},   32'd0);

        // ---- Zero length ----
        doReset();
        applyStimulus(2'b01, 2'b00, 4'd0, 4'd0);
        tick();
        checkOutput("len0_gnt",      {30'd0, bus.gnt},   32'h1);
        tick();
        checkOutput("len0_cnt_done", {30'd0, bus.done},  32'd0);
        tick();
        checkOutput("len0_done",     {30'd0, bus.done},  32'h1);
        checkOutput("len0_ctr",      {28'd0, bus.ctr_q}, 32'd0);
        applyStimulus(2'b00, 2'b00, 4'd0, 4'd0);
        tick();
        checkOutput("len0_end_done", {30'd0, bus.done},  32'd0);

        // ---- Maximum length ----
        doReset();
        applyStimulus(2'b01, 2'b01, 4'd15, 4'd0);
        tick();
        checkOutput("len15_gnt", {30'd0, bus.gnt}, 32'h1);
        cycles = 0;
        hit    = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick();
            cycles++;
            if (bus.done != 2'b00)
                hit = 1'b1;
        end
        checkOutput("len15_done_seen", {31'd0, hit},       32'd1);
        checkOutput("len15_latency",   cycles,             32'd17);
        checkOutput("len15_done",      {30'd0, bus.done},  32'h1);
        checkOutput("len15_ctr",       {28'd0, bus.ctr_q}, 32'd15);
        applyStimulus(2'b00, 2'b00, 4'd15, 4'd0);
        tick();
        checkOutput("len15_no_wrap",   {28'd0, bus.ctr_q}, 32'd15);
        checkOutput("len15_end_done",  {30'd0, bus.done},  32'd0);

        // ---- Abort at count 5, then tie must still go to requester 0 ----
        doReset();
        applyStimulus(2'b01, 2'b01, 4'd10, 4'd0);
        tick();
        waitCount(4'd5, 20, hit);
        checkOutput("abort_ctr5_seen", {31'd0, hit}, 32'd1);
        applyStimulus(2'b00, 2'b01, 4'd10, 4'd0);
        tick();
        checkOutput("abort_gnt",  {30'd0, bus.gnt},   32'd0);
        checkOutput("abort_busy", {31'd0, bus.busy},  32'd0);
        checkOutput("abort_done", {30'd0, bus.done},  32'd0);
        checkOutput("abort_ctr",  {28'd0, bus.ctr_q}, 32'd5);
        tick();
        checkOutput("abort_hold", {28'd0, bus.ctr_q}, 32'd5);
        checkOutput("abort_done2", {30'd0, bus.done}, 32'd0);
        applyStimulus(2'b11, 2'b00, 4'd10, 4'd0);
        tick();
        checkOutput("abort_next_gnt", {30'd0, bus.gnt}, 32'h1);
        applyStimulus(2'b00, 2'b00, 4'd10, 4'd0);
        tick();
        checkOutput("abort_clr_gnt", {30'd0, bus.gnt}, 32'd0);

        // ---- Reset in the middle of a count ----
        doReset();
        applyStimulus(2'b01, 2'b01, 4'd10, 4'd0);
        tick();
        waitCount(4'd6, 20, hit);
        checkOutput("midrst_ctr6_seen", {31'd0, hit}, 32'd1);
        reset = 1'b1;
        applyStimulus(2'b00, 2'b01, 4'd10, 4'd0);
        tick();
        checkOutput("midrst_busy", {31'd0, bus.busy},  32'd0);
        checkOutput("midrst_gnt",  {30'd0, bus.gnt},   32'd0);
        checkOutput("midrst_done", {30'd0, bus.done},  32'd0);
        checkOutput("midrst_ctr",  {28'd0, bus.ctr_q}, 32'd0);
        reset = 1'b0;
        tick();
        tick();
        checkOutput("midrst_no_resume_gnt", {30'd0, bus.gnt},   32'd0);
        checkOutput("midrst_no_resume_ctr", {28'd0, bus.ctr_q}, 32'd0);
        checkOutput("midrst_no_resume_done", {30'd0, bus.done}, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
